// File: rtl/csi_packet_ctrl.sv
// CSI-2 packet sequencer: header assembly with ECC check, short/long classification,
// payload delimiting and CRC footer capture. Optional header correction: PH_CORRECT_EN.

module ecc_block (
  input  logic [29:0] i_ph,
  output logic [23:0] o_data,
  output logic        o_corrected,
  output logic        o_error
);

  // Parity-check column for each of the 24 header data bits
  function automatic logic [5:0] eccCol(input logic [4:0] idx);
    case (idx)
      5'd0:    eccCol = 6'h07;
      5'd1:    eccCol = 6'h0B;
      5'd2:    eccCol = 6'h0D;
      5'd3:    eccCol = 6'h0E;
      5'd4:    eccCol = 6'h13;
      5'd5:    eccCol = 6'h15;
      5'd6:    eccCol = 6'h16;
      5'd7:    eccCol = 6'h19;
      5'd8:    eccCol = 6'h1A;
      5'd9:    eccCol = 6'h1C;
      5'd10:   eccCol = 6'h23;
      5'd11:   eccCol = 6'h25;
      5'd12:   eccCol = 6'h26;
      5'd13:   eccCol = 6'h29;
      5'd14:   eccCol = 6'h2A;
      5'd15:   eccCol = 6'h2C;
      5'd16:   eccCol = 6'h31;
      5'd17:   eccCol = 6'h32;
      5'd18:   eccCol = 6'h34;
      5'd19:   eccCol = 6'h38;
      5'd20:   eccCol = 6'h1F;
      5'd21:   eccCol = 6'h2F;
      5'd22:   eccCol = 6'h37;
      5'd23:   eccCol = 6'h3B;
      default: eccCol = 6'h00;
    endcase
  endfunction

  logic [5:0] w_parity;
  logic [5:0] w_syndrome;

  always_comb begin
    w_parity = '0;
    for (int i = 0; i < 24; i++) begin
      if (i_ph[i]) w_parity = w_parity ^ eccCol(5'(i));
    end
  end

  assign w_syndrome = w_parity ^ i_ph[29:24];

`ifdef PH_CORRECT_EN
  // A syndrome equal to one data column pinpoints the flipped bit; anything else nonzero is fatal
  always_comb begin
    o_data      = i_ph[23:0];
    o_corrected = 1'b0;
    o_error     = (w_syndrome != 6'h00);
    for (int i = 0; i < 24; i++) begin
      if (w_syndrome == eccCol(5'(i))) begin
        o_data[i]   = ~i_ph[i];
        o_corrected = 1'b1;
        o_error     = 1'b0;
      end
    end
  end
`else
  assign o_data      = i_ph[23:0];
  assign o_corrected = 1'b0;
  assign o_error     = (w_syndrome != 6'h00);
`endif

endmodule

module csi_packet_ctrl #(
  parameter logic [5:0] SHORT_DT_MAX = 6'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_active,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        ph_valid,
  output logic [7:0]  data_id,
  output logic [15:0] word_count,
  output logic        ph_corrected,
  output logic        ph_error,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic [15:0] crc_data,
  output logic        crc_valid,
  output logic        pkt_abort,
  output logic        busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HDR      = 3'd1;
  localparam logic [2:0] S_PAYLOAD  = 3'd2;
  localparam logic [2:0] S_CRC      = 3'd3;
  localparam logic [2:0] S_WAIT_END = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_idx;
  logic [23:0] r_hdr;
  logic [15:0] r_cnt;
  logic [7:0]  r_crcLo;
  logic        r_crcIdx;

  logic        w_accept;
  logic [23:0] w_eccData;
  logic        w_eccCorr;
  logic        w_eccErr;
  logic [5:0]  w_dt;
  logic [15:0] w_wc;

  assign w_accept = rx_active & byte_valid;
  assign w_dt     = w_eccData[5:0];
  assign w_wc     = w_eccData[23:8];
  assign busy     = (r_state != S_IDLE);

  // ECC byte bits [7:6] are reserved, so only the low six reach the checker
  ecc_block u_ecc (
    .i_ph        ({byte_in[5:0], r_hdr}),
    .o_data      (w_eccData),
    .o_corrected (w_eccCorr),
    .o_error     (w_eccErr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_idx         <= 2'd0;
      r_hdr         <= '0;
      r_cnt         <= '0;
      r_crcLo       <= '0;
      r_crcIdx      <= 1'b0;
      ph_valid      <= 1'b0;
      data_id       <= '0;
      word_count    <= '0;
      ph_corrected  <= 1'b0;
      ph_error      <= 1'b0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      crc_data      <= '0;
      crc_valid     <= 1'b0;
      pkt_abort     <= 1'b0;
    end else begin
      ph_valid      <= 1'b0;
      payload_valid <= 1'b0;
      payload_last  <= 1'b0;
      crc_valid     <= 1'b0;
      pkt_abort     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hdr[7:0] <= byte_in;
            r_idx      <= 2'd1;
            r_state    <= S_HDR;
          end
        end

        S_HDR: begin
          if (!rx_active) begin
            r_state   <= S_IDLE;
            pkt_abort <= 1'b1;
          end else if (byte_valid) begin
            case (r_idx)
              2'd1: begin
                r_hdr[15:8] <= byte_in;
                r_idx       <= 2'd2;
              end
              2'd2: begin
                r_hdr[23:16] <= byte_in;
                r_idx        <= 2'd3;
              end
              default: begin
                ph_valid     <= 1'b1;
                data_id      <= w_eccData[7:0];
                word_count   <= w_wc;
                ph_corrected <= w_eccCorr;
                ph_error     <= w_eccErr;
                r_idx        <= 2'd0;
                if (w_eccErr || (w_dt <= SHORT_DT_MAX)) begin
                  r_state <= S_WAIT_END;
                end else if (w_wc != 16'd0) begin
                  r_cnt   <= w_wc;
                  r_state <= S_PAYLOAD;
                end else begin
                  r_crcIdx <= 1'b0;
                  r_state  <= S_CRC;
                end
              end
            endcase
          end
        end

        S_PAYLOAD: begin
          if (!rx_active) begin
            r_state   <= S_IDLE;
            pkt_abort <= 1'b1;
          end else if (byte_valid) begin
            payload_valid <= 1'b1;
            payload_data  <= byte_in;
            r_cnt         <= r_cnt - 16'd1;
            if (r_cnt == 16'd1) begin
              payload_last <= 1'b1;
              r_crcIdx     <= 1'b0;
              r_state      <= S_CRC;
            end
          end
        end

        // First footer byte is staged so crc_data only changes together with crc_valid
        S_CRC: begin
          if (!rx_active) begin
            r_state   <= S_IDLE;
            pkt_abort <= 1'b1;
          end else if (byte_valid) begin
            if (!r_crcIdx) begin
              r_crcLo  <= byte_in;
              r_crcIdx <= 1'b1;
            end else begin
              crc_data  <= {byte_in, r_crcLo};
              crc_valid <= 1'b1;
              r_crcIdx  <= 1'b0;
              r_state   <= S_WAIT_END;
            end
          end
        end

        S_WAIT_END: begin
          if (!rx_active) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csi_packet_ctrl.sv
// Directed testbench for csi_packet_ctrl; header expectations depend on PH_CORRECT_EN.

module tb_csi_packet_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_active = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        ph_valid;
  logic [7:0]  data_id;
  logic [15:0] word_count;
  logic        ph_corrected;
  logic        ph_error;
  logic [7:0]  payload_data;
  logic        payload_valid;
  logic        payload_last;
  logic [15:0] crc_data;
  logic        crc_valid;
  logic        pkt_abort;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  csi_packet_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .rx_active     (rx_active),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .ph_valid      (ph_valid),
    .data_id       (data_id),
    .word_count    (word_count),
    .ph_corrected  (ph_corrected),
    .ph_error      (ph_error),
    .payload_data  (payload_data),
    .payload_valid (payload_valid),
    .payload_last  (payload_last),
    .crc_data      (crc_data),
    .crc_valid     (crc_valid),
    .pkt_abort     (pkt_abort),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Event log sampled on the falling edge; tests compare deltas against a snapshot
  int          cyc = 0;
  int          phCnt = 0;
  int          crcCnt = 0;
  int          abortCnt = 0;
  int          phCycle = 0;
  int          crcCycle = 0;
  logic [7:0]  logDi = 8'h00;
  logic [15:0] logWc = 16'h0000;
  logic        logCorr = 1'b0;
  logic        logErr = 1'b0;
  logic [15:0] logCrc = 16'h0000;
  logic [7:0]  payData[$];
  logic        payLast[$];
  int          payCyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (ph_valid) begin
        phCnt   <= phCnt + 1;
        phCycle <= cyc;
        logDi   <= data_id;
        logWc   <= word_count;
        logCorr <= ph_corrected;
        logErr  <= ph_error;
      end
      if (payload_valid) begin
        payData.push_back(payload_data);
        payLast.push_back(payload_last);
        payCyc.push_back(cyc);
      end
      if (crc_valid) begin
        crcCnt   <= crcCnt + 1;
        crcCycle <= cyc;
        logCrc   <= crc_data;
      end
      if (pkt_abort) abortCnt <= abortCnt + 1;
    end
  end

  int phBase, payBase, crcBase, abBase;

  task automatic snapshot();
    phBase  = phCnt;
    payBase = payData.size();
    crcBase = crcCnt;
    abBase  = abortCnt;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_active  = 1'b1;
    byte_valid = 1'b1;
    byte_in    = b;
  endtask

  task automatic sendBytes(input logic [7:0] b [0:7], input int n);
    for (int i = 0; i < n; i++) applyStimulus(b[i]);
  endtask

  task automatic endBurst();
    @(negedge clk);
    rx_active  = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [7:0] payAt(input int k);
    return (payData.size() > k) ? payData[k] : 8'hxx;
  endfunction

  function automatic logic lastAt(input int k);
    return (payLast.size() > k) ? payLast[k] : 1'bx;
  endfunction

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    compared++; if (ph_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset ph_valid: got %b want 0", ph_valid); end
    compared++; if (data_id !== 8'h00) begin mismatched++; $display("[TB] FAIL reset data_id: got %h want 00", data_id); end
    compared++; if (word_count !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset word_count: got %h want 0000", word_count); end
    compared++; if (ph_corrected !== 1'b0) begin mismatched++; $display("[TB] FAIL reset ph_corrected: got %b want 0", ph_corrected); end
    compared++; if (ph_error !== 1'b0) begin mismatched++; $display("[TB] FAIL reset ph_error: got %b want 0", ph_error); end
    compared++; if (payload_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset payload_data: got %h want 00", payload_data); end
    compared++; if (payload_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset payload_valid: got %b want 0", payload_valid); end
    compared++; if (payload_last !== 1'b0) begin mismatched++; $display("[TB] FAIL reset payload_last: got %b want 0", payload_last); end
    compared++; if (crc_data !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset crc_data: got %h want 0000", crc_data); end
    compared++; if (crc_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset crc_valid: got %b want 0", crc_valid); end
    compared++; if (pkt_abort !== 1'b0) begin mismatched++; $display("[TB] FAIL reset pkt_abort: got %b want 0", pkt_abort); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_short();
    snapshot();
    sendBytes('{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    @(negedge clk);
    byte_valid = 1'b0;
    compared++; if (ph_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL short ph_valid timing: got %b want 1", ph_valid); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL short busy in packet: got %b want 1", busy); end
    endBurst();
    compared++; if (phCnt - phBase !== 1) begin mismatched++; $display("[TB] FAIL short ph count: got %0d want 1", phCnt - phBase); end
    compared++; if (logDi !== 8'h00) begin mismatched++; $display("[TB] FAIL short data_id: got %h want 00", logDi); end
    compared++; if (logWc !== 16'h0000) begin mismatched++; $display("[TB] FAIL short word_count: got %h want 0000", logWc); end
    compared++; if ({logCorr, logErr} !== 2'b00) begin mismatched++; $display("[TB] FAIL short flags: got %b want 00", {logCorr, logErr}); end
    compared++; if (payData.size() - payBase !== 0) begin mismatched++; $display("[TB] FAIL short payload count: got %0d want 0", payData.size() - payBase); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL short idle after end: got %b want 0", busy); end
  endtask

  task automatic test_long();
    snapshot();
    sendBytes('{8'h2A, 8'h02, 8'h00, 8'h0C, 8'hAA, 8'h55, 8'h34, 8'h12}, 8);
    endBurst();
    compared++; if (phCnt - phBase !== 1) begin mismatched++; $display("[TB] FAIL long ph count: got %0d want 1", phCnt - phBase); end
    compared++; if (logDi !== 8'h2A) begin mismatched++; $display("[TB] FAIL long data_id: got %h want 2a", logDi); end
    compared++; if (logWc !== 16'h0002) begin mismatched++; $display("[TB] FAIL long word_count: got %h want 0002", logWc); end
    compared++; if ({logCorr, logErr} !== 2'b00) begin mismatched++; $display("[TB] FAIL long flags: got %b want 00", {logCorr, logErr}); end
    compared++; if (payData.size() - payBase !== 2) begin mismatched++; $display("[TB] FAIL long payload count: got %0d want 2", payData.size() - payBase); end
    compared++; if ({payAt(payBase), lastAt(payBase)} !== {8'hAA, 1'b0}) begin mismatched++; $display("[TB] FAIL long payload0: got %h/%b want aa/0", payAt(payBase), lastAt(payBase)); end
    compared++; if ({payAt(payBase + 1), lastAt(payBase + 1)} !== {8'h55, 1'b1}) begin mismatched++; $display("[TB] FAIL long payload1: got %h/%b want 55/1", payAt(payBase + 1), lastAt(payBase + 1)); end
    compared++; if (((payCyc.size() > payBase) ? payCyc[payBase] - phCycle : -1) !== 1) begin mismatched++; $display("[TB] FAIL long first payload latency: got %0d want 1", (payCyc.size() > payBase) ? payCyc[payBase] - phCycle : -1); end
    compared++; if (crcCnt - crcBase !== 1) begin mismatched++; $display("[TB] FAIL long crc count: got %0d want 1", crcCnt - crcBase); end
    compared++; if (logCrc !== 16'h1234) begin mismatched++; $display("[TB] FAIL long crc_data: got %h want 1234", logCrc); end
    compared++; if (crcCycle - phCycle !== 4) begin mismatched++; $display("[TB] FAIL long crc timing: got %0d want 4", crcCycle - phCycle); end
    compared++; if (abortCnt - abBase !== 0) begin mismatched++; $display("[TB] FAIL long abort count: got %0d want 0", abortCnt - abBase); end
  endtask

  task automatic test_payload_gaps();
    snapshot();
    sendBytes('{8'h2A, 8'h02, 8'h00, 8'h0C, 8'hAA, 8'h00, 8'h00, 8'h00}, 5);
    @(negedge clk); byte_valid = 1'b0;
    applyStimulus(8'h55);
    @(negedge clk); byte_valid = 1'b0;
    applyStimulus(8'h34);
    @(negedge clk); byte_valid = 1'b0;
    applyStimulus(8'h12);
    endBurst();
    compared++; if (payData.size() - payBase !== 2) begin mismatched++; $display("[TB] FAIL gaps payload count: got %0d want 2", payData.size() - payBase); end
    compared++; if ({payAt(payBase + 1), lastAt(payBase + 1), lastAt(payBase)} !== {8'h55, 1'b1, 1'b0}) begin mismatched++; $display("[TB] FAIL gaps payload/last: got %h/%b/%b want 55/1/0", payAt(payBase + 1), lastAt(payBase + 1), lastAt(payBase)); end
    compared++; if (((payCyc.size() > payBase + 1) ? payCyc[payBase + 1] - payCyc[payBase] : -1) !== 2) begin mismatched++; $display("[TB] FAIL gaps spacing: got %0d want 2", (payCyc.size() > payBase + 1) ? payCyc[payBase + 1] - payCyc[payBase] : -1); end
    compared++; if ({crcCnt - crcBase, 16'(logCrc)} !== {32'd1, 16'h1234}) begin mismatched++; $display("[TB] FAIL gaps crc: got %0d/%h want 1/1234", crcCnt - crcBase, logCrc); end
  endtask

  task automatic test_dt_boundary();
    // DT 0x0F is the last short type: WC carries data and nothing follows
    snapshot();
    sendBytes('{8'h0F, 8'h34, 8'h12, 8'h0E, 8'h99, 8'h98, 8'h00, 8'h00}, 6);
    endBurst();
    compared++; if ({logDi, logWc} !== {8'h0F, 16'h1234}) begin mismatched++; $display("[TB] FAIL dt0f header: got %h/%h want 0f/1234", logDi, logWc); end
    compared++; if ((payData.size() - payBase) + (crcCnt - crcBase) !== 0) begin mismatched++; $display("[TB] FAIL dt0f no payload/crc: got %0d want 0", (payData.size() - payBase) + (crcCnt - crcBase)); end
    // DT 0x10 is long; WC 0 goes straight to the footer
    snapshot();
    sendBytes('{8'h10, 8'h00, 8'h00, 8'h13, 8'h01, 8'h02, 8'h00, 8'h00}, 6);
    endBurst();
    compared++; if ({phCnt - phBase, logDi, logWc, logErr} !== {32'd1, 8'h10, 16'h0000, 1'b0}) begin mismatched++; $display("[TB] FAIL dt10 header: got %0d/%h/%h/%b want 1/10/0000/0", phCnt - phBase, logDi, logWc, logErr); end
    compared++; if (payData.size() - payBase !== 0) begin mismatched++; $display("[TB] FAIL dt10 payload count: got %0d want 0", payData.size() - payBase); end
    compared++; if ({crcCnt - crcBase, 16'(logCrc)} !== {32'd1, 16'h0201}) begin mismatched++; $display("[TB] FAIL dt10 crc: got %0d/%h want 1/0201", crcCnt - crcBase, logCrc); end
  endtask

  task automatic test_single_bit();
    snapshot();
    sendBytes('{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00}, 6);
    endBurst();
    compared++; if (phCnt - phBase !== 1) begin mismatched++; $display("[TB] FAIL single ph count: got %0d want 1", phCnt - phBase); end
`ifdef PH_CORRECT_EN
    compared++; if ({logDi, logCorr, logErr} !== {8'h00, 1'b1, 1'b0}) begin mismatched++; $display("[TB] FAIL single corrected: got %h/%b/%b want 00/1/0", logDi, logCorr, logErr); end
`else
    compared++; if ({logCorr, logErr} !== 2'b01) begin mismatched++; $display("[TB] FAIL single error flags: got %b want 01", {logCorr, logErr}); end
`endif
    compared++; if (payData.size() - payBase !== 0) begin mismatched++; $display("[TB] FAIL single payload count: got %0d want 0", payData.size() - payBase); end
  endtask

  task automatic test_double_bit();
    snapshot();
    sendBytes('{8'h03, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00}, 7);
    @(negedge clk);
    byte_valid = 1'b0;
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL double busy in wait: got %b want 1", busy); end
    endBurst();
    compared++; if ({logCorr, logErr} !== 2'b01) begin mismatched++; $display("[TB] FAIL double flags: got %b want 01", {logCorr, logErr}); end
    compared++; if ((payData.size() - payBase) + (crcCnt - crcBase) + (abortCnt - abBase) !== 0) begin mismatched++; $display("[TB] FAIL double ignored bytes: got %0d events want 0", (payData.size() - payBase) + (crcCnt - crcBase) + (abortCnt - abBase)); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL double idle after end: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    snapshot();
    sendBytes('{8'h2A, 8'h02, 8'h00, 8'h0C, 8'hAA, 8'h00, 8'h00, 8'h00}, 5);
    endBurst();
    compared++; if (payData.size() - payBase !== 1) begin mismatched++; $display("[TB] FAIL abort payload count: got %0d want 1", payData.size() - payBase); end
    compared++; if ({payAt(payBase), lastAt(payBase)} !== {8'hAA, 1'b0}) begin mismatched++; $display("[TB] FAIL abort payload0: got %h/%b want aa/0", payAt(payBase), lastAt(payBase)); end
    compared++; if (abortCnt - abBase !== 1) begin mismatched++; $display("[TB] FAIL abort pulse count: got %0d want 1", abortCnt - abBase); end
    compared++; if ({crcCnt - crcBase, busy} !== {32'd0, 1'b0}) begin mismatched++; $display("[TB] FAIL abort crc/busy: got %0d/%b want 0/0", crcCnt - crcBase, busy); end
  endtask

  task automatic test_back_to_back();
    snapshot();
    sendBytes('{8'h2A, 8'h02, 8'h00, 8'h0C, 8'hAA, 8'h55, 8'h34, 8'h12}, 8);
    endBurst();
    sendBytes('{8'h2B, 8'h01, 8'h00, 8'h0D, 8'h5A, 8'hCD, 8'hAB, 8'h00}, 7);
    endBurst();
    compared++; if ({phCnt - phBase, logDi, logWc} !== {32'd2, 8'h2B, 16'h0001}) begin mismatched++; $display("[TB] FAIL b2b second header: got %0d/%h/%h want 2/2b/0001", phCnt - phBase, logDi, logWc); end
    compared++; if ({payAt(payBase + 2), lastAt(payBase + 2)} !== {8'h5A, 1'b1}) begin mismatched++; $display("[TB] FAIL b2b second payload: got %h/%b want 5a/1", payAt(payBase + 2), lastAt(payBase + 2)); end
    compared++; if ({crcCnt - crcBase, 16'(logCrc)} !== {32'd2, 16'hABCD}) begin mismatched++; $display("[TB] FAIL b2b second crc: got %0d/%h want 2/abcd", crcCnt - crcBase, logCrc); end
  endtask

  task automatic test_reset_midpacket();
    sendBytes('{8'h2A, 8'h02, 8'h00, 8'h0C, 8'hAA, 8'h00, 8'h00, 8'h00}, 5);
    @(negedge clk);
    byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    compared++; if ({payload_valid, payload_data, busy} !== {1'b0, 8'h00, 1'b0}) begin mismatched++; $display("[TB] FAIL midreset payload/busy: got %b/%h/%b want 0/00/0", payload_valid, payload_data, busy); end
    compared++; if ({data_id, word_count, crc_data} !== {8'h00, 16'h0000, 16'h0000}) begin mismatched++; $display("[TB] FAIL midreset held fields: got %h/%h/%h want 00/0000/0000", data_id, word_count, crc_data); end
    @(negedge clk);
    reset = 1'b0;
    snapshot();
    sendBytes('{8'h0F, 8'h34, 8'h12, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    endBurst();
    compared++; if ({phCnt - phBase, logDi, logWc, logErr} !== {32'd1, 8'h0F, 16'h1234, 1'b0}) begin mismatched++; $display("[TB] FAIL midreset next packet: got %0d/%h/%h/%b want 1/0f/1234/0", phCnt - phBase, logDi, logWc, logErr); end
    compared++; if ((payData.size() - payBase) + (abortCnt - abBase) !== 0) begin mismatched++; $display("[TB] FAIL midreset stray events: got %0d want 0", (payData.size() - payBase) + (abortCnt - abBase)); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_payload_gaps();
    test_dt_boundary();
    test_single_bit();
    test_double_bit();
    test_abort();
    test_back_to_back();
    test_reset_midpacket();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
